// File: rtl/xm23_display_pkg.sv
// Shared types and constants for the XM23 cycle-count seven-segment display.
package xm23_display_pkg;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_LOAD,
        DISP_SHIFT,
        DISP_COMMIT
    } disp_state_t;

    // Active-low segment patterns, bit0=a .. bit6=g.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Double-dabble correction: a BCD nibble of 5 or more would exceed 9 after
    // the next doubling, so it is pre-biased by 3.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage

// File: rtl/seg7_digit_encode.sv
// Combinational BCD digit to active-low seven-segment encoder.
// Priority: dash > blank > digit table. Codes above 9 are shown blank.
module seg7_digit_encode
    import xm23_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // Select dash, blank or the table entry for this digit.
    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            for (int unsigned i = 0; i < 10; i++) begin
                if (bcd == 4'(i)) begin
                    seg = SEG_DIGIT[i];
                end
            end
        end
    end

endmodule

// File: rtl/cycle_count_display.sv
// Sequential binary-to-BCD converter and multi-digit seven-segment driver for
// the XM23 global cycle counter. A sample is taken in LOAD, converted by
// shift-add-3 over BIN_W cycles, then committed to the display registers in
// one step so the digits never show a partial result.
module cycle_count_display
    import xm23_display_pkg::*;
#(
    parameter int unsigned BIN_W         = 27,
    parameter int unsigned DIGITS        = 8,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   init,
    input  logic [BIN_W-1:0]       binary_in,
    input  logic                   freeze,
    output logic [DIGITS-1:0][6:0] segments,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    // One extra BCD digit above the displayed ones detects overflow.
    localparam int unsigned BCD_W    = 4 * (DIGITS + 1);
    localparam logic [4:0]  CNT_LAST = 5'(BIN_W - 1);

    disp_state_t              state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic                     carry_q, carry_d;
    logic [DIGITS-1:0][3:0]   disp_q, disp_d;
    logic                     ovf_q, ovf_d;
    logic                     done_q, done_d;

    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W-1:0]         bcd_step;
    logic [DIGITS-1:0]        blank_mask;
    logic                     upper_zero;

    // Apply the add-3 correction to every nibble, then double with the binary MSB shifted in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i <= DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3_if_ge5(bcd_q[4*i +: 4]);
        end
        bcd_step = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    end

    // Next-state logic for the conversion FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        carry_d = carry_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            DISP_IDLE: begin
                if (!freeze) begin
                    state_d = DISP_LOAD;
                end
            end
            DISP_LOAD: begin
                bin_d   = binary_in;
                bcd_d   = '0;
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = DISP_SHIFT;
            end
            DISP_SHIFT: begin
                bcd_d   = bcd_step;
                bin_d   = {bin_q[BIN_W-2:0], 1'b0};
                // A bit falling off the top BCD digit can only occur if BIN_W
                // outgrows DIGITS+1 decimal digits; keep it as sticky overflow.
                carry_d = carry_q | bcd_adj[BCD_W-1];
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DISP_COMMIT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DISP_COMMIT: begin
                disp_d  = bcd_q[4*DIGITS-1:0];
                ovf_d   = carry_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);
                // done is registered with the display so it marks the first
                // cycle in which the new digits are visible.
                done_d  = 1'b1;
                state_d = DISP_IDLE;
            end
            default: begin
                state_d = DISP_IDLE;
            end
        endcase
    end

    // State and datapath registers; init aborts any conversion in flight.
    always_ff @(posedge clk_in or posedge init) begin
        if (init) begin
            state_q <= DISP_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Leading-zero mask: digit k blanks when it and every digit above it are zero.
    always_comb begin
        blank_mask = '0;
        upper_zero = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero & (disp_q[k] == 4'd0);
            blank_mask[k] = BLANK_LEADING & upper_zero;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_digit_encode u_enc (
            .bcd   (disp_q[g]),
            .blank (blank_mask[g]),
            .dash  (ovf_q),
            .seg   (segments[g])
        );
    end

    assign busy     = (state_q == DISP_LOAD) || (state_q == DISP_SHIFT);
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
